// File: rtl/dt_mask_scan_pkg.sv
// Shared constants, FSM encoding and statistics record for the distance-transform post-processing blocks.
package dt_mask_scan_pkg;
   localparam int DATA_W  = 8;
   localparam int IMG_W   = 128;
   localparam int IMG_H   = 128;
   localparam int PIX_N   = IMG_W * IMG_H;
   localparam int RES_AW  = $clog2(PIX_N);
   localparam int WORD_W  = 16;
   localparam int WORD_AW = RES_AW - 4;
   localparam int CNT_W   = RES_AW + 1;
   localparam int SUM_W   = DATA_W + RES_AW;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SCAN  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_FIN   = 2'd3;

   typedef struct packed {
      logic [DATA_W-1:0] max_val;
      logic [RES_AW-1:0] max_addr;
      logic [CNT_W-1:0]  fg_cnt;
      logic [SUM_W-1:0]  dist_sum;
   } stats_t;

   function automatic logic mask_bit(input logic [DATA_W-1:0] v, input logic [DATA_W-1:0] t);
      return v >= t;
   endfunction
endpackage

// File: rtl/dt_mask_scan_if.sv
// Result-RAM read port and mask-RAM write port of the mask scanner.
interface dt_mask_scan_if;
   import dt_mask_scan_pkg::*;

   logic                res_rd;
   logic [RES_AW-1:0]   res_addr;
   logic [DATA_W-1:0]   res_di;
   logic                msk_wr;
   logic [WORD_AW-1:0]  msk_addr;
   logic [WORD_W-1:0]   msk_do;

   modport master (output res_rd, res_addr, msk_wr, msk_addr, msk_do, input res_di);
   modport slave  (input res_rd, res_addr, msk_wr, msk_addr, msk_do, output res_di);
endinterface

// File: rtl/dt_stat_acc.sv
// Running map statistics: max value with first address, non-zero count and sum of distances.
module dt_stat_acc
   import dt_mask_scan_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              en_i,
   input  logic              clr_i,
   input  logic [DATA_W-1:0] pix_i,
   input  logic [RES_AW-1:0] addr_i,
   output stats_t            stats_o
);
   stats_t stats_q, stats_d;

   always_comb begin
      stats_d = stats_q;
      if (clr_i) begin
         stats_d = '0;
      end else if (en_i) begin
         stats_d.dist_sum = stats_q.dist_sum + SUM_W'(pix_i);
         stats_d.fg_cnt   = stats_q.fg_cnt + CNT_W'(pix_i != '0);
         // strict compare so an equal later value keeps the earlier address
         if (pix_i > stats_q.max_val) begin
            stats_d.max_val  = pix_i;
            stats_d.max_addr = addr_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) stats_q <= '0;
      else       stats_q <= stats_d;
   end

   assign stats_o = stats_q;
endmodule

// File: rtl/dt_mask_scan.sv
// Raster-scans the distance map, packs thresholded pixels into 16-bit mask words and gathers statistics.
module dt_mask_scan
   import dt_mask_scan_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] thresh,
   dt_mask_scan_if.master    bus,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] max_val,
   output logic [RES_AW-1:0] max_addr,
   output logic [CNT_W-1:0]  fg_cnt,
   output logic [SUM_W-1:0]  dist_sum
);
   localparam logic [RES_AW-1:0] LAST_ADDR = RES_AW'(PIX_N - 1);

   logic [1:0]         state_q, state_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               rd_q, rd_d;
   logic [RES_AW-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  thr_q, thr_d;
   logic               vld_p1_q;
   logic [RES_AW-1:0]  addr_p1_q;
   logic [WORD_W-1:0]  shreg_q, shreg_d;
   logic               wr_q, wr_d;
   logic [WORD_AW-1:0] waddr_q, waddr_d;
   logic [WORD_W-1:0]  wdata_q, wdata_d;
   logic               accept;
   stats_t             stats;

   assign accept = (state_q == ST_IDLE) && start;

   always_comb begin
      state_d = state_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      rd_d    = rd_q;
      addr_d  = addr_q;
      thr_d   = thr_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_SCAN;
               busy_d  = 1'b1;
               rd_d    = 1'b1;
               addr_d  = '0;
               thr_d   = thresh;
            end
         end
         ST_SCAN: begin
            if (addr_q == LAST_ADDR) begin
               rd_d    = 1'b0;
               state_d = ST_DRAIN;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (vld_p1_q && (addr_p1_q == LAST_ADDR)) state_d = ST_FIN;
         end
         ST_FIN: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // stage p1: read data arrives, mask bit shifted in MSB-first
   always_comb begin
      shreg_d = shreg_q;
      wr_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      if (vld_p1_q) begin
         shreg_d = {shreg_q[WORD_W-2:0], mask_bit(bus.res_di, thr_q)};
         if (&addr_p1_q[3:0]) begin
            wr_d    = 1'b1;
            waddr_d = addr_p1_q[RES_AW-1:4];
            wdata_d = shreg_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rd_q      <= 1'b0;
         addr_q    <= '0;
         thr_q     <= '0;
         vld_p1_q  <= 1'b0;
         addr_p1_q <= '0;
         shreg_q   <= '0;
         wr_q      <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rd_q      <= rd_d;
         addr_q    <= addr_d;
         thr_q     <= thr_d;
         vld_p1_q  <= rd_q;
         addr_p1_q <= addr_q;
         shreg_q   <= shreg_d;
         wr_q      <= wr_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
      end
   end

   dt_stat_acc u_acc (
      .clk     (clk),
      .reset   (reset),
      .en_i    (vld_p1_q),
      .clr_i   (accept),
      .pix_i   (bus.res_di),
      .addr_i  (addr_p1_q),
      .stats_o (stats)
   );

   assign bus.res_rd   = rd_q;
   assign bus.res_addr = addr_q;
   assign bus.msk_wr   = wr_q;
   assign bus.msk_addr = waddr_q;
   assign bus.msk_do   = wdata_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign max_val      = stats.max_val;
   assign max_addr     = stats.max_addr;
   assign fg_cnt       = stats.fg_cnt;
   assign dist_sum     = stats.dist_sum;
endmodule

// File: tb/tb_dt_mask_scan.sv
// Bench for dt_mask_scan: result-RAM model, map-level reference model and per-cycle output comparison.
module tb_dt_mask_scan;
   import dt_mask_scan_pkg::*;

   localparam int N        = 16384;
   localparam int DONE_CYC = N + 3;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [7:0]  thresh;
   logic        busy, done;
   logic [7:0]  max_val;
   logic [13:0] max_addr;
   logic [14:0] fg_cnt;
   logic [21:0] dist_sum;

   dt_mask_scan_if bus();

   dt_mask_scan dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .thresh   (thresh),
      .bus      (bus),
      .busy     (busy),
      .done     (done),
      .max_val  (max_val),
      .max_addr (max_addr),
      .fg_cnt   (fg_cnt),
      .dist_sum (dist_sum)
   );

   always #5 clk = ~clk;

   logic [7:0]  map  [N];
   logic [15:0] mram [N/16];
   logic [15:0] exp_word [N/16];
   int exp_max, exp_maxa, exp_fg, exp_sum;
   int checks = 0;
   int errors = 0;

   // synchronous-read result RAM
   always @(posedge clk) if (bus.res_rd) bus.res_di <= map[bus.res_addr];

   task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d got %0h want %0h", name, cyc, act, exp);
      end
   endtask

   task automatic build_model(input logic [7:0] thr);
      exp_max = 0; exp_maxa = -1; exp_fg = 0; exp_sum = 0;
      for (int w = 0; w < N/16; w++) begin
         exp_word[w] = '0;
         for (int i = 0; i < 16; i++)
            if (map[w*16+i] >= thr) exp_word[w][15-i] = 1'b1;
      end
      for (int a = 0; a < N; a++) begin
         exp_sum += int'(map[a]);
         if (map[a] != 8'd0) exp_fg++;
         if (int'(map[a]) > exp_max) exp_max = int'(map[a]);
      end
      for (int a = 0; a < N; a++)
         if (exp_maxa < 0 && int'(map[a]) == exp_max) exp_maxa = a;
   endtask

   task automatic check_zero(input string name, input int cyc);
      chk({name, "_busy"}, cyc, busy, 0);
      chk({name, "_done"}, cyc, done, 0);
      chk({name, "_res_rd"}, cyc, bus.res_rd, 0);
      chk({name, "_res_addr"}, cyc, bus.res_addr, 0);
      chk({name, "_msk_wr"}, cyc, bus.msk_wr, 0);
      chk({name, "_msk_addr"}, cyc, bus.msk_addr, 0);
      chk({name, "_msk_do"}, cyc, bus.msk_do, 0);
      chk({name, "_max_val"}, cyc, max_val, 0);
      chk({name, "_max_addr"}, cyc, max_addr, 0);
      chk({name, "_fg_cnt"}, cyc, fg_cnt, 0);
      chk({name, "_dist_sum"}, cyc, dist_sum, 0);
   endtask

   // start in cycle 0, compare every later cycle; optional ignored restart and reset abort
   task automatic run_scan(input logic [7:0] thr, input int restart_at, input int abort_at);
      int  ndone, nwr;
      bit  aborted;
      logic e_rd, e_wr;
      ndone = 0; nwr = 0; aborted = 0;
      for (int w = 0; w < N/16; w++) mram[w] = 16'hDEAD;
      @(negedge clk);
      start = 1'b1; thresh = thr;
      @(posedge clk);
      for (int c = 1; c <= DONE_CYC + 4; c++) begin
         @(negedge clk);
         start = 1'b0; thresh = thr;
         e_rd = (c <= N);
         e_wr = (c >= 3) && (c <= N + 2) && (((c - 3) % 16) == 15);
         chk("busy", c, busy, (c <= N + 2));
         chk("done", c, done, (c == DONE_CYC));
         chk("res_rd", c, bus.res_rd, e_rd);
         if (e_rd) chk("res_addr", c, bus.res_addr, c - 1);
         chk("msk_wr", c, bus.msk_wr, e_wr);
         if (e_wr) begin
            chk("msk_addr", c, bus.msk_addr, (c - 3) / 16);
            chk("msk_do", c, bus.msk_do, exp_word[(c - 3) / 16]);
         end
         if (bus.msk_wr) begin
            mram[bus.msk_addr] = bus.msk_do;
            nwr++;
         end
         if (done) ndone++;
         if (c == 1) begin
            chk("clr_max_val", c, max_val, 0);
            chk("clr_fg_cnt", c, fg_cnt, 0);
            chk("clr_dist_sum", c, dist_sum, 0);
         end
         if (c >= N + 2) begin
            chk("max_val", c, max_val, exp_max);
            chk("max_addr", c, max_addr, exp_maxa);
            chk("fg_cnt", c, fg_cnt, exp_fg);
            chk("dist_sum", c, dist_sum, exp_sum);
         end
         if (c > N + 2) begin
            chk("hold_msk_addr", c, bus.msk_addr, N/16 - 1);
            chk("hold_msk_do", c, bus.msk_do, exp_word[N/16 - 1]);
         end
         if (c == restart_at) begin
            start = 1'b1; thresh = ~thr;
         end
         if (c == abort_at) begin
            aborted = 1;
            break;
         end
      end
      if (aborted) begin
         reset = 1'b1;
         @(negedge clk);
         check_zero("rst_mid", abort_at + 1);
         start = 1'b1;
         @(negedge clk);
         check_zero("rst_with_start", abort_at + 2);
         start = 1'b0; reset = 1'b0;
         @(negedge clk);
         chk("after_rst_busy", abort_at + 3, busy, 0);
         chk("after_rst_res_rd", abort_at + 3, bus.res_rd, 0);
      end else begin
         chk("done_count", DONE_CYC, ndone, 1);
         chk("write_count", DONE_CYC, nwr, N/16);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; thresh = 8'd0;
      repeat (3) @(negedge clk);
      check_zero("reset", 0);
      start = 1'b1;
      @(negedge clk);
      check_zero("reset_start", 0);
      reset = 1'b0; start = 1'b0;
      @(negedge clk);
      check_zero("idle", 0);

      // ramp map with a second start at cycle 100 that must be ignored
      for (int a = 0; a < N; a++) map[a] = 8'(a);
      build_model(8'd128);
      run_scan(8'd128, 100, 0);
      chk("ramp_max_val", 0, max_val, 255);
      chk("ramp_max_addr", 0, max_addr, 255);
      chk("ramp_fg_cnt", 0, fg_cnt, 16320);
      chk("ramp_dist_sum", 0, dist_sum, 64 * 32640);
      chk("ramp_word0", 0, mram[0], 16'h0000);
      chk("ramp_word8", 0, mram[8], 16'hFFFF);
      chk("ramp_word17", 0, mram[17], 16'h0000);
      repeat (5) @(negedge clk);
      chk("ramp_stable_max", 0, max_val, 255);
      chk("ramp_stable_sum", 0, dist_sum, 64 * 32640);

      // single pixel, aborted by reset at cycle 500, then rerun
      for (int a = 0; a < N; a++) map[a] = 8'd0;
      map[5000] = 8'd7;
      build_model(8'd7);
      run_scan(8'd7, 0, 500);
      run_scan(8'd7, 0, 0);
      chk("single_word312", 0, mram[312], 16'h0080);
      chk("single_word311", 0, mram[311], 16'h0000);
      chk("single_max_val", 0, max_val, 7);
      chk("single_max_addr", 0, max_addr, 5000);
      chk("single_fg_cnt", 0, fg_cnt, 1);
      chk("single_dist_sum", 0, dist_sum, 7);

      // two equal maxima with threshold zero
      for (int a = 0; a < N; a++) map[a] = 8'd0;
      map[100] = 8'd9; map[9000] = 8'd9;
      build_model(8'd0);
      run_scan(8'd0, 0, 0);
      chk("tie_max_addr", 0, max_addr, 100);
      chk("tie_max_val", 0, max_val, 9);
      chk("tie_fg_cnt", 0, fg_cnt, 2);
      chk("tie_dist_sum", 0, dist_sum, 18);
      chk("tie_word0", 0, mram[0], 16'hFFFF);
      chk("tie_word1023", 0, mram[1023], 16'hFFFF);

      // sparse random map, random threshold
      for (int a = 0; a < N; a++)
         map[a] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      thresh = 8'($urandom_range(1, 255));
      build_model(thresh);
      run_scan(thresh, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
